pipeline_hazard_controller: RTL and testbench
=============================================

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 Parameter: FLUSH_CYCLES, 2, cycles ifIdFlush/idExFlush stay asserted per taken branch (legal 1..7).
REQ-002 Parameter: COUNT_WIDTH, 32, width of each performance counter.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: idRs1, idRs2  input  5 each  source register indices of instruction in ID.
REQ-006 Port: idUsesRs1, idUsesRs2  input  1 each  ID instruction actually reads that source.
REQ-007 Port: exRd  input  5  destination register of instruction in EX.
REQ-008 Port: exIsMemRead  input  1  EX instruction is a load.
REQ-009 Port: exBranchTaken  input  1  EX resolved a taken branch/jump this cycle.
REQ-010 Port: exMultiCycleStart, exMultiCycleDone  input  1 each  EX multi-cycle unit begins / finishes.
REQ-011 Port: pcWrite, ifIdWrite  output  1 each  enable PC and IF/ID barrier update.
REQ-012 Port: ifIdFlush, idExFlush  output  1 each  load bubble into IF/ID, ID/EX barrier.
REQ-013 Port: exHold  output  1  freeze ID/EX barrier and EX inputs.
REQ-014 Port: ctrlState  output  2  current FSM state (RUN=0, MC_STALL=1, FLUSH=2).
REQ-015 Port: stallCycles, flushCycles  output  COUNT_WIDTH each  performance counters.

Function
REQ-016 FSM states RUN, MC_STALL, FLUSH plus 3-bit flushRemain counter; control outputs combinational from state and inputs.
REQ-017 Default (no hazard) outputs: pcWrite=1, ifIdWrite=1, ifIdFlush=0, idExFlush=0, exHold=0.
REQ-018 loadUse = exIsMemRead & exRd!=0 & ((idUsesRs1 & idRs1==exRd) | (idUsesRs2 & idRs2==exRd)).
REQ-019 RUN priority: exBranchTaken > multi-cycle start > loadUse.
REQ-020 RUN + exBranchTaken: ifIdFlush=1, idExFlush=1, pcWrite=1; if FLUSH_CYCLES>1 go FLUSH with flushRemain=FLUSH_CYCLES-1, else stay RUN.
REQ-021 RUN + exMultiCycleStart & !exMultiCycleDone: pcWrite=0, ifIdWrite=0, exHold=1; next MC_STALL.
REQ-022 RUN + exMultiCycleStart & exMultiCycleDone same cycle: default outputs, stay RUN.
REQ-023 RUN + loadUse: pcWrite=0, ifIdWrite=0, idExFlush=1 (one-cycle bubble); stay RUN.
REQ-024 MC_STALL: pcWrite=0, ifIdWrite=0, exHold=1 until exMultiCycleDone; done cycle outputs default, next RUN.
REQ-025 MC_STALL ignores exBranchTaken and loadUse.
REQ-026 FLUSH: ifIdFlush=1, idExFlush=1, pcWrite=1, ifIdWrite=1; flushRemain decrements; flushRemain==1 -> next RUN.
REQ-027 FLUSH ignores exBranchTaken, exMultiCycleStart and loadUse.

Reset
REQ-028 reset low: state=RUN, flushRemain=0, counters=0 immediately, independent of clk.
REQ-029 While reset low: pcWrite=0, ifIdWrite=0, ifIdFlush=1, idExFlush=1, exHold=0, ctrlState=0.
REQ-030 Reset mid-MC_STALL or mid-FLUSH aborts the sequence; first cycle after release is RUN.

Configuration
REQ-031 Macro HAZARD_PERF_COUNTERS_EN defined: stallCycles +1 every clk with reset high and pcWrite=0; flushCycles +1 every clk with ifIdFlush=1; both saturate at all-ones.
REQ-032 Macro undefined: counter logic absent, stallCycles and flushCycles tied to 0, ports retained.

Verification
REQ-033 exIsMemRead=1, exRd=5, idRs1=5, idUsesRs1=1 in RUN -> pcWrite=0, ifIdWrite=0, idExFlush=1 one cycle; exRd=0 -> no stall.
REQ-034 exBranchTaken=1, FLUSH_CYCLES=2 -> both flushes high 2 cycles (RUN cycle + 1 FLUSH), ctrlState 0->2->0.
REQ-035 exMultiCycleStart=1, exMultiCycleDone after 4 cycles -> pcWrite=0, exHold=1 for 4 cycles, release in done cycle; stallCycles=4 with macro.
REQ-036 exBranchTaken and loadUse and exMultiCycleStart same cycle -> branch flush only, next FLUSH.
REQ-037 reset low during MC_STALL cycle 2 -> ctrlState=0 and flushes=1 asynchronously; counters=0.
REQ-038 Macro undefined, 10-cycle stall -> stallCycles=0, flushCycles=0.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: load-use bubbles, multi-cycle EX stalls and
// taken-branch flushes for a classic five-stage pipeline.
// Optional feature macro: HAZARD_PERF_COUNTERS_EN enables the stall/flush
// performance counters; when undefined the counter ports are tied to zero.
module pipeline_hazard_controller #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned COUNT_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4:0]             idRs1,
    input  logic [4:0]             idRs2,
    input  logic                   idUsesRs1,
    input  logic                   idUsesRs2,
    input  logic [4:0]             exRd,
    input  logic                   exIsMemRead,
    input  logic                   exBranchTaken,
    input  logic                   exMultiCycleStart,
    input  logic                   exMultiCycleDone,
    output logic                   pcWrite,
    output logic                   ifIdWrite,
    output logic                   ifIdFlush,
    output logic                   idExFlush,
    output logic                   exHold,
    output logic [1:0]             ctrlState,
    output logic [COUNT_WIDTH-1:0] stallCycles,
    output logic [COUNT_WIDTH-1:0] flushCycles
);

    localparam int unsigned STATE_W  = 2;
    localparam int unsigned REMAIN_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN      = 2'd0,
        ST_MC_STALL = 2'd1,
        ST_FLUSH    = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [REMAIN_W-1:0] flush_remain_q, flush_remain_d;
    logic                load_use;

    // Load in EX whose destination feeds a source the ID instruction reads
    always_comb begin
        load_use = exIsMemRead && (exRd != 5'd0) &&
                   ((idUsesRs1 && (idRs1 == exRd)) ||
                    (idUsesRs2 && (idRs2 == exRd)));
    end

    // State register and flush countdown; reset aborts any stall/flush in progress
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_RUN;
            flush_remain_q <= '0;
        end else begin
            state_q        <= state_d;
            flush_remain_q <= flush_remain_d;
        end
    end

    // Next-state logic: branch beats multi-cycle start; load-use never changes state
    always_comb begin
        state_d        = state_q;
        flush_remain_d = flush_remain_q;
        case (state_q)
            ST_RUN: begin
                if (exBranchTaken) begin
                    if (FLUSH_CYCLES > 1) begin
                        state_d        = ST_FLUSH;
                        flush_remain_d = REMAIN_W'(FLUSH_CYCLES - 1);
                    end
                end else if (exMultiCycleStart && !exMultiCycleDone) begin
                    state_d = ST_MC_STALL;
                end
            end
            ST_MC_STALL: begin
                if (exMultiCycleDone) begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (flush_remain_q <= REMAIN_W'(1)) begin
                    state_d        = ST_RUN;
                    flush_remain_d = '0;
                end else begin
                    flush_remain_d = flush_remain_q - REMAIN_W'(1);
                end
            end
            default: begin
                state_d        = ST_RUN;
                flush_remain_d = '0;
            end
        endcase
    end

    // Control outputs from state and live EX/ID inputs; reset forces a flushed, frozen front end
    always_comb begin
        pcWrite   = 1'b1;
        ifIdWrite = 1'b1;
        ifIdFlush = 1'b0;
        idExFlush = 1'b0;
        exHold    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (exBranchTaken) begin
                    ifIdFlush = 1'b1;
                    idExFlush = 1'b1;
                end else if (exMultiCycleStart) begin
                    if (!exMultiCycleDone) begin
                        pcWrite   = 1'b0;
                        ifIdWrite = 1'b0;
                        exHold    = 1'b1;
                    end
                end else if (load_use) begin
                    pcWrite   = 1'b0;
                    ifIdWrite = 1'b0;
                    idExFlush = 1'b1;
                end
            end
            ST_MC_STALL: begin
                if (!exMultiCycleDone) begin
                    pcWrite   = 1'b0;
                    ifIdWrite = 1'b0;
                    exHold    = 1'b1;
                end
            end
            ST_FLUSH: begin
                ifIdFlush = 1'b1;
                idExFlush = 1'b1;
            end
            default: begin
            end
        endcase
        if (!reset) begin
            pcWrite   = 1'b0;
            ifIdWrite = 1'b0;
            ifIdFlush = 1'b1;
            idExFlush = 1'b1;
            exHold    = 1'b0;
        end
    end

    assign ctrlState = state_q;

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [COUNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q;

    // Saturating counters of frozen-PC cycles and IF/ID flush cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pcWrite && (stall_cnt_q != {COUNT_WIDTH{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + COUNT_WIDTH'(1);
            end
            if (ifIdFlush && (flush_cnt_q != {COUNT_WIDTH{1'b1}})) begin
                flush_cnt_q <= flush_cnt_q + COUNT_WIDTH'(1);
            end
        end
    end

    assign stallCycles = stall_cnt_q;
    assign flushCycles = flush_cnt_q;
`else
    assign stallCycles = '0;
    assign flushCycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: a cycle-level model of
// the hazard rules checked on every falling edge, plus directed literal checks.
module tb_pipeline_hazard_controller;

    localparam int unsigned FC = 2;
    localparam int unsigned CW = 32;
`ifdef HAZARD_PERF_COUNTERS_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    idRs1, idRs2, exRd;
    logic          idUsesRs1, idUsesRs2, exIsMemRead, exBranchTaken;
    logic          exMultiCycleStart, exMultiCycleDone;
    logic          pcWrite, ifIdWrite, ifIdFlush, idExFlush, exHold;
    logic [1:0]    ctrlState;
    logic [CW-1:0] stallCycles, flushCycles;

    int checks   = 0;
    int failures = 0;

    pipeline_hazard_controller #(.FLUSH_CYCLES(FC), .COUNT_WIDTH(CW)) dut (
        .clk               (clk),
        .reset             (reset),
        .idRs1             (idRs1),
        .idRs2             (idRs2),
        .idUsesRs1         (idUsesRs1),
        .idUsesRs2         (idUsesRs2),
        .exRd              (exRd),
        .exIsMemRead       (exIsMemRead),
        .exBranchTaken     (exBranchTaken),
        .exMultiCycleStart (exMultiCycleStart),
        .exMultiCycleDone  (exMultiCycleDone),
        .pcWrite           (pcWrite),
        .ifIdWrite         (ifIdWrite),
        .ifIdFlush         (ifIdFlush),
        .idExFlush         (idExFlush),
        .exHold            (exHold),
        .ctrlState         (ctrlState),
        .stallCycles       (stallCycles),
        .flushCycles       (flushCycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, got, exp);
        end
    endtask

    // Model: remaining flush cycles, "inside a multi-cycle op" flag, counter totals
    int      m_flush_left = 0;
    bit      m_mc = 1'b0;
    longint  m_stall = 0, m_flush = 0;
    longint  sat_max = (64'd1 << CW) - 1;
    bit      e_pc, e_ifw, e_iff, e_idf, e_hold, lu;
    int      e_st;

    always @(negedge clk) begin
        e_pc = 1; e_ifw = 1; e_iff = 0; e_idf = 0; e_hold = 0; e_st = 0;
        lu = exIsMemRead && exRd != 0 &&
             ((idUsesRs1 && idRs1 == exRd) || (idUsesRs2 && idRs2 == exRd));
        if (!reset) begin
            m_flush_left = 0; m_mc = 0; m_stall = 0; m_flush = 0;
            e_pc = 0; e_ifw = 0; e_iff = 1; e_idf = 1;
        end else if (m_flush_left > 0) begin
            e_st = 2; e_iff = 1; e_idf = 1;
        end else if (m_mc) begin
            e_st = 1;
            if (!exMultiCycleDone) begin e_pc = 0; e_ifw = 0; e_hold = 1; end
        end else if (exBranchTaken) begin
            e_iff = 1; e_idf = 1;
        end else if (exMultiCycleStart) begin
            if (!exMultiCycleDone) begin e_pc = 0; e_ifw = 0; e_hold = 1; end
        end else if (lu) begin
            e_pc = 0; e_ifw = 0; e_idf = 1;
        end
        check("m_pcWrite",   64'(pcWrite),   64'(e_pc));
        check("m_ifIdWrite", 64'(ifIdWrite), 64'(e_ifw));
        check("m_ifIdFlush", 64'(ifIdFlush), 64'(e_iff));
        check("m_idExFlush", 64'(idExFlush), 64'(e_idf));
        check("m_exHold",    64'(exHold),    64'(e_hold));
        check("m_ctrlState", 64'(ctrlState), 64'(e_st));
        check("m_stallCycles", 64'(stallCycles), PERF ? 64'(m_stall) : 64'd0);
        check("m_flushCycles", 64'(flushCycles), PERF ? 64'(m_flush) : 64'd0);
        if (reset) begin
            if (!e_pc && m_stall < sat_max) m_stall++;
            if (e_iff && m_flush < sat_max) m_flush++;
            if (m_flush_left > 0) m_flush_left--;
            else if (m_mc) begin if (exMultiCycleDone) m_mc = 0; end
            else if (exBranchTaken) m_flush_left = FC - 1;
            else if (exMultiCycleStart && !exMultiCycleDone) m_mc = 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        idRs1 = 0; idRs2 = 0; exRd = 0; idUsesRs1 = 0; idUsesRs2 = 0;
        exIsMemRead = 0; exBranchTaken = 0; exMultiCycleStart = 0; exMultiCycleDone = 0;
    endtask

    initial begin
        reset = 1'b0;
        clear_in();
        repeat (2) @(posedge clk);
        #2;
        check("rst_pcWrite",   64'(pcWrite),   64'd0);
        check("rst_ifIdWrite", 64'(ifIdWrite), 64'd0);
        check("rst_ifIdFlush", 64'(ifIdFlush), 64'd1);
        check("rst_idExFlush", 64'(idExFlush), 64'd1);
        check("rst_exHold",    64'(exHold),    64'd0);
        check("rst_state",     64'(ctrlState), 64'd0);
        check("rst_stall",     64'(stallCycles), 64'd0);
        reset = 1'b1;
        #1 check("idle_pcWrite", 64'(pcWrite), 64'd1);
        tick();

        // load-use on rs1
        exIsMemRead = 1; exRd = 5; idRs1 = 5; idUsesRs1 = 1;
        #1 check("lu_pcWrite",   64'(pcWrite),   64'd0);
        check("lu_ifIdWrite",    64'(ifIdWrite), 64'd0);
        check("lu_idExFlush",    64'(idExFlush), 64'd1);
        check("lu_ifIdFlush",    64'(ifIdFlush), 64'd0);
        tick();
        exRd = 0; idRs1 = 0;
        #1 check("lu_x0_pcWrite", 64'(pcWrite), 64'd1);
        tick();
        // load-use on rs2 only, then same registers but source unused
        exRd = 7; idRs1 = 7; idRs2 = 7; idUsesRs1 = 0; idUsesRs2 = 1;
        #1 check("lu_rs2_pcWrite", 64'(pcWrite), 64'd0);
        tick();
        idUsesRs2 = 0;
        #1 check("lu_unused_pcWrite", 64'(pcWrite), 64'd1);
        tick();
        clear_in();

        // taken branch: flush in RUN cycle plus one FLUSH cycle
        exBranchTaken = 1;
        #1 check("br_ifIdFlush", 64'(ifIdFlush), 64'd1);
        check("br_state0",       64'(ctrlState), 64'd0);
        tick();
        exBranchTaken = 0;
        #1 check("br_state2",    64'(ctrlState), 64'd2);
        check("br_idExFlush2",   64'(idExFlush), 64'd1);
        tick();
        #1 check("br_back_state", 64'(ctrlState), 64'd0);
        check("br_back_flush",    64'(ifIdFlush), 64'd0);
        tick();

        // branch + load-use + multi-cycle start: branch wins, FLUSH ignores new requests
        exBranchTaken = 1; exMultiCycleStart = 1; exIsMemRead = 1; exRd = 3; idRs1 = 3; idUsesRs1 = 1;
        #1 check("pri_exHold", 64'(exHold),  64'd0);
        check("pri_pcWrite",   64'(pcWrite), 64'd1);
        tick();
        #1 check("pri_state",  64'(ctrlState), 64'd2);
        check("pri_fl_pcWrite", 64'(pcWrite),  64'd1);
        tick();
        clear_in();
        #1 check("pri_after_state", 64'(ctrlState), 64'd0);
        tick();

        // multi-cycle op: start + 3 stall cycles, released in done cycle
        exMultiCycleStart = 1;
        #1 check("mc_start_hold", 64'(exHold), 64'd1);
        tick();
        exMultiCycleStart = 0;
        #1 check("mc_state1", 64'(ctrlState), 64'd1);
        tick();
        exBranchTaken = 1; exIsMemRead = 1; exRd = 4; idRs1 = 4; idUsesRs1 = 1;
        #1 check("mc_ign_flush", 64'(ifIdFlush), 64'd0);
        check("mc_ign_pcWrite",  64'(pcWrite),   64'd0);
        tick();
        clear_in();
        tick();
        exMultiCycleDone = 1;
        #1 check("mc_done_pcWrite", 64'(pcWrite), 64'd1);
        check("mc_done_state",      64'(ctrlState), 64'd1);
        tick();
        exMultiCycleDone = 0;
        #1 check("mc_after_state", 64'(ctrlState), 64'd0);
        check("cnt_stall_6", 64'(stallCycles), PERF ? 64'd6 : 64'd0);
        check("cnt_flush_4", 64'(flushCycles), PERF ? 64'd4 : 64'd0);
        tick();

        // start and done together: no stall
        exMultiCycleStart = 1; exMultiCycleDone = 1;
        #1 check("sd_pcWrite", 64'(pcWrite), 64'd1);
        tick();
        clear_in();
        #1 check("sd_state", 64'(ctrlState), 64'd0);
        tick();

        // asynchronous reset in MC_STALL cycle 2
        exMultiCycleStart = 1;
        tick();
        exMultiCycleStart = 0;
        tick();
        #1 check("ar_pre_state", 64'(ctrlState), 64'd1);
        reset = 1'b0;
        #1 check("ar_state",  64'(ctrlState),   64'd0);
        check("ar_ifIdFlush", 64'(ifIdFlush),   64'd1);
        check("ar_idExFlush", 64'(idExFlush),   64'd1);
        check("ar_stall",     64'(stallCycles), 64'd0);
        check("ar_flush",     64'(flushCycles), 64'd0);
        tick();
        reset = 1'b1;
        #1 check("ar_rel_state", 64'(ctrlState), 64'd0);
        check("ar_rel_pcWrite",  64'(pcWrite),   64'd1);
        tick();

        // 10-cycle stall: start + 9 stall cycles + done
        exMultiCycleStart = 1;
        tick();
        exMultiCycleStart = 0;
        repeat (9) tick();
        exMultiCycleDone = 1;
        tick();
        exMultiCycleDone = 0;
        #1 check("ten_stall", 64'(stallCycles), PERF ? 64'd10 : 64'd0);
        check("ten_flush",    64'(flushCycles), 64'd0);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
